// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: reset/bubble defaults, opcode constants,
// and the IF/ID pipeline record used by the fetch stage.
package mips_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

  localparam logic [5:0] OPCODE_RTYPE = 6'b000000;
  localparam logic [5:0] OPCODE_J     = 6'b000010;
  localparam logic [5:0] OPCODE_BEQ   = 6'b000100;

  // Source of the next PC, listed from lowest to highest priority.
  typedef enum logic [1:0] {
    PC_SEQ    = 2'd0,
    PC_HOLD   = 2'd1,
    PC_BRANCH = 2'd2,
    PC_JUMP   = 2'd3
  } pc_sel_e;

  typedef enum logic [1:0] {
    IFID_LOAD   = 2'd0,
    IFID_HOLD   = 2'd1,
    IFID_BUBBLE = 2'd2
  } if_id_op_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
    logic        valid;
  } if_id_t;

  // J-type target: upper nibble of the delay-slot PC plus the 26-bit word index.
  function automatic logic [31:0] jump_target(input logic [31:0] pc_plus4,
                                              input logic [31:0] instr);
    return {pc_plus4[31:28], instr[25:0], 2'b00};
  endfunction

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: loads, holds or bubbles the fetched instruction and
// counts every valid instruction handed to decode.
module if_id_reg
  import mips_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        bubble,
  input  logic [31:0] fetch_instr,
  input  logic [31:0] fetch_pc_plus4,
  output logic [31:0] instr,
  output logic [31:0] pc_plus4,
  output logic        valid,
  output logic [31:0] count
);

  if_id_t    if_id_r;
  logic [31:0] count_r;
  if_id_op_e op_s;
  if_id_t    bubble_s;
  if_id_t    fetched_s;

  assign bubble_s  = '{instr: NOP_INSTR, pc_plus4: 32'h0000_0000, valid: 1'b0};
  assign fetched_s = '{instr: fetch_instr, pc_plus4: fetch_pc_plus4, valid: 1'b1};

  // Bubble beats stall so a flush during a hold still squashes the slot.
  always_comb begin
    op_s = IFID_LOAD;
    if (bubble) begin
      op_s = IFID_BUBBLE;
    end else if (stall) begin
      op_s = IFID_HOLD;
    end else begin
      op_s = IFID_LOAD;
    end
  end

  // Pipeline register update.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_id_r <= bubble_s;
    end else begin
      case (op_s)
        IFID_LOAD:   if_id_r <= fetched_s;
        IFID_HOLD:   if_id_r <= if_id_r;
        IFID_BUBBLE: if_id_r <= bubble_s;
        default:     if_id_r <= bubble_s;
      endcase
    end
  end

  // Valid-fetch counter; wraps naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= 32'h0000_0000;
    end else if (op_s == IFID_LOAD) begin
      count_r <= count_r + 32'd1;
    end else begin
      count_r <= count_r;
    end
  end

  assign instr    = if_id_r.instr;
  assign pc_plus4 = if_id_r.pc_plus4;
  assign valid    = if_id_r.valid;
  assign count    = count_r;

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction fetch: PC register, prioritised next-PC selection and the
// IF/ID register feeding decode.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic [31:0] fetch_count
);

  logic [31:0] pc_r;
  logic [31:0] pc_plus4_s;
  logic [31:0] next_pc_s;
  pc_sel_e     pc_sel_s;
  logic        redirect_s;
  logic        bubble_s;

  assign pc_plus4_s = pc_r + 32'd4;
  assign redirect_s = jump | branch_taken;
  assign bubble_s   = redirect_s | flush;

  // Redirects outrank stall; jump outranks branch.
  always_comb begin
    pc_sel_s = PC_SEQ;
    if (jump) begin
      pc_sel_s = PC_JUMP;
    end else if (branch_taken) begin
      pc_sel_s = PC_BRANCH;
    end else if (stall) begin
      pc_sel_s = PC_HOLD;
    end else begin
      pc_sel_s = PC_SEQ;
    end
  end

  // Next-PC mux; the jump target comes from the instruction already in IF/ID.
  always_comb begin
    next_pc_s = pc_plus4_s;
    case (pc_sel_s)
      PC_SEQ:    next_pc_s = pc_plus4_s;
      PC_HOLD:   next_pc_s = pc_r;
      PC_BRANCH: next_pc_s = word_align(branch_target);
      PC_JUMP:   next_pc_s = jump_target(if_id_pc_plus4, if_id_instr);
      default:   next_pc_s = pc_plus4_s;
    endcase
  end

  // Program counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r <= RESET_PC;
    end else begin
      pc_r <= next_pc_s;
    end
  end

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .bubble         (bubble_s),
    .fetch_instr    (imem_rdata),
    .fetch_pc_plus4 (pc_plus4_s),
    .instr          (if_id_instr),
    .pc_plus4       (if_id_pc_plus4),
    .valid          (if_id_valid),
    .count          (fetch_count)
  );

  assign imem_addr = pc_r;
  assign opcode    = if_id_instr[31:26];
  assign funct     = if_id_instr[5:0];

endmodule
